keypad_scanner: RTL and testbench

//  Scans a 4x4 active-low matrix keypad, debounces presses and releases, and emits one 4-bit
//  key code with a single-cycle strobe per accepted press. Sits directly upstream of the digit

---
 rtl/keypad_scanner.sv | 188 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debouncing and a one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to build the auto-repeat counter.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_RATE     = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  // Deciding one cycle early lets the registered outputs land on the Nth stable cycle.
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 2);
  localparam logic [DebW-1:0] DebMax  = DebW'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_cfg
    $error("keypad_scanner: all timing parameters must be >= 2");
  end

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e            state_q, state_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        pattern_q, pattern_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [DebW-1:0]   deb_q, deb_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic [3:0]        rows_meta_q, rows_s_q;

  logic [3:0] rows_low;
  logic       one_low;
  logic [1:0] low_idx;
  logic       row_up;
  logic       rpt_fire;

  assign rows_low = ~rows_s_q;
  assign one_low  = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
  assign row_up   = rows_s_q[row_idx_q];

  always_comb begin
    low_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rows_low[i]) low_idx = 2'(i);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax);
  localparam logic [RptW-1:0] RptFirst = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptNext  = RptW'(REPEAT_RATE - 1);

  logic [RptW-1:0] rpt_q, rpt_d;
  logic            rpt_done_q, rpt_done_d;
  logic            rpt_hold;

  // Counter only survives while the key stays down in PRESSED; any exit restarts the full delay.
  assign rpt_hold = (state_q == StPressed) && !row_up;
  assign rpt_fire = rpt_hold && (rpt_q == (rpt_done_q ? RptNext : RptFirst));

  always_comb begin
    rpt_d      = '0;
    rpt_done_d = 1'b0;
    if (rpt_hold) begin
      rpt_done_d = rpt_done_q | rpt_fire;
      if (!rpt_fire && rpt_q != RptW'(RptMax - 1)) rpt_d = rpt_q + RptW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q      <= '0;
      rpt_done_q <= 1'b0;
    end else begin
      rpt_q      <= rpt_d;
      rpt_done_q <= rpt_done_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    pattern_d = pattern_q;
    dwell_d   = dwell_q;
    deb_d     = deb_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StScan: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (one_low) begin
            state_d   = StDebounce;
            row_idx_d = low_idx;
            pattern_d = rows_s_q;
            deb_d     = '0;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end
      StDebounce: begin
        if (rows_s_q != pattern_q) begin
          state_d   = StScan;
          col_idx_d = col_idx_q + 2'd1;
          deb_d     = '0;
        end else if (deb_q == DebLast) begin
          state_d = StPressed;
          code_d  = {row_idx_q, col_idx_q};
          valid_d = 1'b1;
          deb_d   = '0;
        end else if (deb_q != DebMax) begin
          deb_d = deb_q + DebW'(1);
        end
      end
      StPressed: begin
        if (row_up) begin
          state_d = StRelease;
          deb_d   = '0;
        end else if (rpt_fire) begin
          valid_d = 1'b1;
        end
      end
      StRelease: begin
        if (!row_up) begin
          state_d = StPressed;
          deb_d   = '0;
        end else if (deb_q == DebLast) begin
          state_d   = StScan;
          col_idx_d = col_idx_q + 2'd1;
          deb_d     = '0;
        end else if (deb_q != DebMax) begin
          deb_d = deb_q + DebW'(1);
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StScan;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      pattern_q   <= 4'hf;
      dwell_q     <= '0;
      deb_q       <= '0;
      code_q      <= 4'd0;
      valid_q     <= 1'b0;
      rows_meta_q <= 4'hf;
      rows_s_q    <= 4'hf;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      pattern_q   <= pattern_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      rows_meta_q <= rows_n;
      rows_s_q    <= rows_meta_q;
    end
  end

  assign cols_n    = ~(4'b0001 << col_idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == StPressed) || (state_q == StRelease);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model plus a timeline reference that
// predicts scan columns, strobes and held intervals arithmetically from each press window.
module tb_keypad_scanner;

  localparam int ScanDiv = 4;
  localparam int Deb     = 8;
  localparam int RptDly  = 40;
  localparam int RptRate = 10;

  logic       clk;
  logic       reset;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  int          cyc;
  int          errors;
  int          checks;
  int          origin;
  int          origin_col;
  logic [3:0]  exp_code;

  keypad_scanner #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_CYCLES(Deb),
    .REPEAT_DELAY   (RptDly),
    .REPEAT_RATE    (RptRate)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows_n   (rows_n),
    .cols_n   (cols_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Key (r,c) pulls row r low only while column c is driven low.
  always_comb begin
    rows_n = 4'hf;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
      end
    end
  end

  function automatic int sched_col(input int o, input int oc, input int t);
    return (oc + (t - o) / ScanDiv) % 4;
  endfunction

  function automatic logic [3:0] col_bits(input int col);
    logic [3:0] v;
    v = 4'b0001 << col;
    return ~v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    keys  = '0;
    repeat (3) begin
      @(negedge clk);
      checks += 4;
      if (cols_n !== 4'b1110) begin
        errors++; $display("FAIL reset_cols cyc=%0d got=%b want=1110", cyc, cols_n);
      end
      if (key_code !== 4'd0) begin
        errors++; $display("FAIL reset_code cyc=%0d got=%h want=0", cyc, key_code);
      end
      if (key_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid cyc=%0d got=%b want=0", cyc, key_valid);
      end
      if (key_held !== 1'b0) begin
        errors++; $display("FAIL reset_held cyc=%0d got=%b want=0", cyc, key_held);
      end
    end
    reset      = 1'b0;
    origin     = cyc;
    origin_col = 0;
    exp_code   = 4'd0;
  endtask

  task automatic test_scan_idle(input int n);
    logic [3:0] ecols;
    repeat (n) begin
      @(negedge clk);
      ecols = col_bits(sched_col(origin, origin_col, cyc));
      checks += 2;
      if (cols_n !== ecols) begin
        errors++; $display("FAIL idle_cols cyc=%0d got=%b want=%b", cyc, cols_n, ecols);
      end
      if (key_valid !== 1'b0) begin
        errors++; $display("FAIL idle_valid cyc=%0d got=%b want=0", cyc, key_valid);
      end
    end
  endtask

  task automatic test_ghost(input int n);
    logic [3:0] ecols;
    repeat (n) begin
      @(negedge clk);
      ecols = col_bits(sched_col(origin, origin_col, cyc));
      checks += 3;
      if (cols_n !== ecols) begin
        errors++; $display("FAIL ghost_cols cyc=%0d got=%b want=%b", cyc, cols_n, ecols);
      end
      if (key_valid !== 1'b0) begin
        errors++; $display("FAIL ghost_valid cyc=%0d got=%b want=0", cyc, key_valid);
      end
      if (key_held !== 1'b0) begin
        errors++; $display("FAIL ghost_held cyc=%0d got=%b want=0", cyc, key_held);
      end
      keys = 16'h2002;
    end
    keys = '0;
    test_scan_idle(4);
  endtask

  // Drives one key from tp=now+1+gap for `hold` cycles and checks every following cycle.
  // glitch: a 3-cycle lift shortly after acceptance; rst_mid: reset at debounce count 5.
  task automatic run_press(input int r, input int c, input int gap, input int hold,
                           input bit glitch, input bit rst_mid);
    int tp, tr, k, ks, ga, fix_end, new_col, last, t, col, nsteps;
    bit seen, acc, found, ev, eh, press;
    logic [3:0] ec, ecols;
    tp    = cyc + 1 + gap;
    tr    = tp + hold;
    found = 1'b0;
    k     = 0;
    for (int j = tp + 2; j < tp + 40; j++) begin
      if (!found && (j - origin) % ScanDiv == ScanDiv - 1 &&
          sched_col(origin, origin_col, j) == c) begin
        found = 1'b1;
        k     = j;
      end
    end
    if (rst_mid) tr = k + 7;
    seen = tr > k - 2;
    acc  = !rst_mid && tr >= k + Deb - 2;
    ks   = k + Deb;
    ga   = ks + 4;
    if (rst_mid) begin
      fix_end = k + 7; new_col = 0;
    end else if (acc) begin
      fix_end = tr + Deb + 2; new_col = (c + 1) % 4;
    end else if (seen) begin
      fix_end = tr + 3; new_col = (c + 1) % 4;
    end else begin
      fix_end = origin; new_col = origin_col;
    end
    last   = ((tr > fix_end) ? tr : fix_end) + 6;
    nsteps = last - cyc;
    repeat (nsteps) begin
      @(negedge clk);
      t = cyc;
      if (!seen || t <= k) col = sched_col(origin, origin_col, t);
      else if (t < fix_end) col = c;
      else col = sched_col(fix_end, new_col, t);
      ecols = col_bits(col);
      ev = acc && t == ks;
`ifdef KEYPAD_REPEAT_EN
      if (acc && !glitch && t >= ks + RptDly && (t - ks - RptDly) % RptRate == 0 && t <= tr + 2)
        ev = 1'b1;
`endif
      eh = acc && t >= ks && t < tr + Deb + 2;
      if (rst_mid && t >= k + 7) ec = 4'd0;
      else if (acc && t >= ks) ec = 4'(r * 4 + c);
      else ec = exp_code;
      checks += 4;
      if (cols_n !== ecols) begin
        errors++; $display("FAIL press_cols cyc=%0d got=%b want=%b", t, cols_n, ecols);
      end
      if (key_valid !== ev) begin
        errors++; $display("FAIL press_valid cyc=%0d got=%b want=%b", t, key_valid, ev);
      end
      if (key_held !== eh) begin
        errors++; $display("FAIL press_held cyc=%0d got=%b want=%b", t, key_held, eh);
      end
      if (key_code !== ec) begin
        errors++; $display("FAIL press_code cyc=%0d got=%h want=%h", t, key_code, ec);
      end
      if (rst_mid && t == k + 6) reset = 1'b1;
      if (rst_mid && t == k + 7) reset = 1'b0;
      press = t >= tp && t < tr && !(glitch && acc && t >= ga && t < ga + 3);
      keys  = press ? (16'd1 << (r * 4 + c)) : 16'd0;
    end
    origin     = fix_end;
    origin_col = new_col;
    if (rst_mid) exp_code = 4'd0;
    else if (acc) exp_code = 4'(r * 4 + c);
  endtask

  task automatic test_single_key();
    run_press(2, 1, 3, 30, 1'b0, 1'b0);
  endtask

  task automatic test_bounce();
    int t;
    t = cyc + 1;
    while ((t - origin) % ScanDiv != 0) t++;
    run_press(0, sched_col(origin, origin_col, t), t - cyc - 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_release_glitch();
    run_press(1, 3, 2, 40, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_debounce();
    run_press(3, 2, 1, 30, 1'b0, 1'b1);
  endtask

  task automatic test_random(input int n);
    repeat (n) begin
      run_press(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(15)),
                int'($urandom_range(40, 4)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_long_hold();
    run_press(1, 0, 0, 100, 1'b0, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    keys   = '0;
    errors = 0;
    checks = 0;
    test_reset();
    test_scan_idle(20);
    test_single_key();
    test_bounce();
    test_ghost(24);
    test_release_glitch();
    test_reset_mid_debounce();
    test_random(10);
    test_long_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
